// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: legal widths, feedback modes and the
// maximal-length tap table (Fibonacci form, bit t-1 set for polynomial term x^t).
package lfsr_pkg;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 32;

  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;

  typedef logic [WIDTH_MAX-1:0] tap_mask_t;

  // One mask per width; a width outside the legal range yields zero and is
  // rejected at elaboration by the top level.
  function automatic tap_mask_t tap_mask(input int width);
    tap_mask_t mask;
    mask = '0;
    case (width)
      3:  mask = 32'h0000_0006;
      4:  mask = 32'h0000_000C;
      5:  mask = 32'h0000_0014;
      6:  mask = 32'h0000_0030;
      7:  mask = 32'h0000_0060;
      8:  mask = 32'h0000_00B8;
      9:  mask = 32'h0000_0110;
      10: mask = 32'h0000_0240;
      11: mask = 32'h0000_0500;
      12: mask = 32'h0000_0829;
      13: mask = 32'h0000_100D;
      14: mask = 32'h0000_2015;
      15: mask = 32'h0000_6000;
      16: mask = 32'h0000_D008;
      17: mask = 32'h0001_2000;
      18: mask = 32'h0002_0400;
      19: mask = 32'h0004_0023;
      20: mask = 32'h0009_0000;
      21: mask = 32'h0014_0000;
      22: mask = 32'h0030_0000;
      23: mask = 32'h0042_0000;
      24: mask = 32'h00E1_0000;
      25: mask = 32'h0120_0000;
      26: mask = 32'h0200_0023;
      27: mask = 32'h0400_0013;
      28: mask = 32'h0900_0000;
      29: mask = 32'h1400_0000;
      30: mask = 32'h2000_0029;
      31: mask = 32'h4800_0000;
      32: mask = 32'h8020_0003;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational single-step of the LFSR in either Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int MODE  = MODE_FIB
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_next
);

  localparam tap_mask_t        TAPS_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  generate
    if (MODE == MODE_FIB) begin : g_fib
      assign state_next = {state[WIDTH-2:0], ^(state & TAPS)};
    end else begin : g_gal
      // Same polynomial as the Fibonacci taps: term x^t lands on bit t, plus the
      // constant term on bit 0, so both forms share the same period.
      localparam logic [WIDTH-1:0] GAL_TAPS = {TAPS[WIDTH-2:0], 1'b1};
      assign state_next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_TAPS : '0);
    end
  endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Maximal-length LFSR with seed load, zero-load protection, step counter and
// a one-cycle pulse each time the state returns to its start value.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int          WIDTH = 12,
  parameter int          MODE  = MODE_FIB,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh_en,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] Q_out,
  output logic             max_tick_reg,
  output logic [WIDTH-1:0] step_cnt
);

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $fatal(1, "lfsr_gen: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (MODE != MODE_FIB && MODE != MODE_GAL) begin : g_bad_mode
      $fatal(1, "lfsr_gen: MODE %0d is not Fibonacci or Galois", MODE);
    end
    if (SEED_W == '0) begin : g_bad_seed
      $fatal(1, "lfsr_gen: SEED must be non-zero within WIDTH bits");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] start_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic             tick_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] load_next;

  lfsr_next #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_next (
    .state      (q_reg),
    .state_next (shift_next)
  );

  // A zero seed would lock the register up, so it is replaced by SEED.
  assign load_next = (seed_in == '0) ? SEED_W : seed_in;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      q_reg     <= SEED_W;
      start_reg <= SEED_W;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
    end else if (ld_en) begin
      q_reg     <= load_next;
      start_reg <= load_next;
      cnt_reg   <= '0;
      tick_reg  <= 1'b0;
    end else if (sh_en) begin
      q_reg <= shift_next;
      if (shift_next == start_reg) begin
        tick_reg <= 1'b1;
        cnt_reg  <= '0;
      end else begin
        tick_reg <= 1'b0;
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  assign Q_out        = q_reg;
  assign step_cnt     = cnt_reg;
  assign max_tick_reg = tick_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 12-bit instance, a 4-bit instance and
// six free-running period-measurement instances (widths 3/8/16, both modes).
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sh_en;
  logic        ld_en;
  logic [11:0] seed_in;
  logic [11:0] q12;
  logic [11:0] cnt12;
  logic        tick12;
  logic [3:0]  q4;
  logic [3:0]  cnt4;
  logic        tick4;

  int n_assert = 0;
  int n_fail   = 0;

  lfsr_gen u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sh_en        (sh_en),
    .ld_en        (ld_en),
    .seed_in      (seed_in),
    .Q_out        (q12),
    .max_tick_reg (tick12),
    .step_cnt     (cnt12)
  );

  lfsr_gen #(.WIDTH(4), .MODE(0), .SEED(1)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .sh_en        (sh_en),
    .ld_en        (1'b0),
    .seed_in      (4'h0),
    .Q_out        (q4),
    .max_tick_reg (tick4),
    .step_cnt     (cnt4)
  );

  // Free-running control for the period instances: shift is dropped one cycle in 32.
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  logic aux_rst;
  logic aux_sh;
  assign aux_rst = (cyc < 4);
  assign aux_sh  = (cyc[4:0] != 5'd7);

  logic [5:0][31:0] aux_period;
  logic [5:0]       aux_done;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_aux
      localparam int W = (gi < 2) ? 3 : ((gi < 4) ? 8 : 16);
      logic [W-1:0] q;
      logic [W-1:0] cnt;
      logic         tick;
      logic         sh_q   = 1'b0;
      logic         rst_q  = 1'b1;
      logic         done   = 1'b0;
      int           shifts = 0;
      int           period = 0;

      lfsr_gen #(.WIDTH(W), .MODE(gi % 2), .SEED(1)) u_aux (
        .clk          (clk),
        .rst_n        (aux_rst),
        .sh_en        (aux_sh),
        .ld_en        (1'b0),
        .seed_in      ({W{1'b0}}),
        .Q_out        (q),
        .max_tick_reg (tick),
        .step_cnt     (cnt)
      );

      always @(posedge clk) begin
        sh_q  <= aux_sh && !aux_rst;
        rst_q <= aux_rst;
      end

      always @(negedge clk) begin
        if (rst_q) begin
          shifts <= 0;
          period <= 0;
          done   <= 1'b0;
        end else if (sh_q && !done) begin
          shifts <= shifts + 1;
          if (tick) begin
            period <= shifts + 1;
            done   <= 1'b1;
          end
        end
      end

      assign aux_period[gi] = period;
      assign aux_done[gi]   = done;
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 4095 continuous shifts; the tick must appear only on the last one.
  task automatic run_period(input string tag, input logic [11:0] first_q, input logic [11:0] end_q);
    int bad;
    bad   = 0;
    rst_n = 1'b0;
    ld_en = 1'b0;
    sh_en = 1'b1;
    for (int i = 1; i <= 4095; i++) begin
      step();
      if (i == 1) chk({tag, "_first_q"}, q12, first_q);
      if (q12 == 12'h000 || cnt12 !== 12'(i % 4095) || tick12 !== (i == 4095)) bad++;
    end
    chk({tag, "_end_q"}, q12, end_q);
    chk({tag, "_end_cnt"}, cnt12, 0);
    chk({tag, "_end_tick"}, tick12, 1);
    chk({tag, "_bad_steps"}, bad, 0);
    $display("[%0t] %s: period run done, %0d off-sequence steps", $time, tag, bad);
  endtask

  logic [3:0]  t4  [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [11:0] e12 [5]  = '{12'h003, 12'h007, 12'h00F, 12'h01E, 12'h03D};

  initial begin
    int bad;

    // Reset held 10 cycles with load and shift both requested.
    rst_n   = 1'b1;
    sh_en   = 1'b1;
    ld_en   = 1'b1;
    seed_in = 12'hABC;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rst_q", q12, 12'h001);
      chk("rst_cnt", cnt12, 0);
      chk("rst_tick", tick12, 0);
    end
    chk("rst_q4", q4, 4'h1);
    $display("[%0t] reset hold checked", $time);

    // Full period from reset, both the 12-bit and 4-bit instances.
    rst_n   = 1'b0;
    ld_en   = 1'b0;
    seed_in = 12'h000;
    bad     = 0;
    for (int i = 1; i <= 4095; i++) begin
      step();
      if (i <= 5) chk("fib12_seq", q12, e12[i-1]);
      if (i <= 30) begin
        chk("fib4_seq", q4, t4[i % 15]);
        chk("fib4_tick", tick4, (i % 15) == 0);
      end
      if (q12 == 12'h000 || cnt12 !== 12'(i % 4095) || tick12 !== (i == 4095)) bad++;
    end
    chk("period_end_q", q12, 12'h001);
    chk("period_end_cnt", cnt12, 0);
    chk("period_end_tick", tick12, 1);
    chk("period_bad_steps", bad, 0);
    $display("[%0t] first period done, %0d off-sequence steps", $time, bad);

    // Three more shifts then hold: state and count freeze, tick stays low.
    for (int i = 0; i < 3; i++) step();
    sh_en = 1'b0;
    step();
    step();
    chk("hold_q", q12, 12'h00F);
    chk("hold_cnt", cnt12, 3);
    chk("hold_tick", tick12, 0);
    $display("[%0t] hold checked", $time);

    // Load 0xABC while shifting: load wins, no shift that cycle.
    sh_en   = 1'b1;
    ld_en   = 1'b1;
    seed_in = 12'hABC;
    step();
    chk("ld_abc_q", q12, 12'hABC);
    chk("ld_abc_cnt", cnt12, 0);
    chk("ld_abc_tick", tick12, 0);
    run_period("ld_abc", 12'h579, 12'hABC);

    // Zero load falls back to SEED for both state and start.
    ld_en   = 1'b1;
    seed_in = 12'h000;
    step();
    chk("ld_zero_q", q12, 12'h001);
    chk("ld_zero_cnt", cnt12, 0);
    run_period("ld_zero", 12'h003, 12'h001);

    // Mid-sequence reset after a fresh load: start must revert to SEED.
    ld_en   = 1'b1;
    seed_in = 12'hABC;
    step();
    ld_en = 1'b0;
    for (int i = 0; i < 2000; i++) step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_q", q12, 12'h001);
    chk("mid_rst_cnt", cnt12, 0);
    chk("mid_rst_tick", tick12, 0);
    run_period("mid_rst", 12'h003, 12'h001);

    // Period measurement instances, bounded wait.
    for (int k = 0; k < 60000 && !(&aux_done); k++) step();
    for (int k = 0; k < 6; k++) begin
      int w;
      w = (k < 2) ? 3 : ((k < 4) ? 8 : 16);
      chk($sformatf("aux%0d_done", k), aux_done[k], 1);
      chk($sformatf("aux%0d_period_w%0d_mode%0d", k, w, k % 2), aux_period[k], (1 << w) - 1);
      $display("[%0t] width %0d mode %0d: measured period %0d", $time, w, k % 2, aux_period[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
